// File: rtl/nios_system_pkg.sv
// Shared constants for the Nios II system peripherals.
//   KEY_* : word offsets of the push-button controller register map.
//   KEY_DEBOUNCE_CYC : default debounce length, 10 ms worth of CLK_HZ cycles.
package nios_system_pkg;

   localparam int unsigned CLK_HZ           = 50_000_000;
   localparam int unsigned KEY_DEBOUNCE_CYC = CLK_HZ / 100;

   localparam logic [1:0] KEY_DATA    = 2'd0;
   localparam logic [1:0] KEY_RSVD    = 2'd1;
   localparam logic [1:0] KEY_IRQMASK = 2'd2;
   localparam logic [1:0] KEY_EDGECAP = 2'd3;

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-FF synchroniser, counter debouncer and press detector.
//   clk, reset_n : system clock, synchronous active-low reset
//   key_raw      : asynchronous raw key, active-low
//   stable       : debounced level (1 = released)
//   press        : one-cycle pulse on a debounced 1->0 transition
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_raw,
   output logic stable,
   output logic press
);

   localparam int unsigned CntW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

   logic            sync1_q, sync2_q;
   logic            stable_q, stable_d;
   logic            prev_q;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         // The accept point is also the top of the count, so cnt never wraps.
         if (cnt_q == CntLast) begin
            stable_d = sync2_q;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         stable_q <= 1'b1;
         prev_q   <= 1'b1;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= key_raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         prev_q   <= stable_q;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;
   assign press  = prev_q & ~stable_q;

endmodule

// File: rtl/nios_system_key_ctrl.sv
// Avalon-MM slave for the KEY push-buttons with debouncing, press capture and a maskable IRQ.
//   clk, reset_n : system clock, synchronous active-low reset
//   address      : 0=DATA (1=pressed), 1=RSVD, 2=IRQMASK, 3=EDGECAP (write 1 to clear)
//   chipselect   : slave select; write_n : active-low write strobe
//   writedata    : write data, low WIDTH bits used
//   readdata     : registered read data, one cycle after address
//   in_port      : raw asynchronous keys, active-low
//   irq          : level interrupt, |(EDGECAP & IRQMASK) registered
module nios_system_key_ctrl
   import nios_system_pkg::*;
#(
   parameter int unsigned WIDTH        = 3,
   parameter int unsigned DEBOUNCE_CYC = KEY_DEBOUNCE_CYC
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] stable, press;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;
   logic             wr_en, rd_en;

   logic unused_wdata;
   assign unused_wdata = ^writedata[31:WIDTH];

   for (genvar i = 0; i < WIDTH; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_debounce (
         .clk     (clk),
         .reset_n (reset_n),
         .key_raw (in_port[i]),
         .stable  (stable[i]),
         .press   (press[i])
      );
   end

   assign wr_en = chipselect & ~write_n;
   assign rd_en = chipselect & write_n;

   always_comb begin
      mask_d    = mask_q;
      edgecap_d = edgecap_q;
      if (wr_en && (address == KEY_IRQMASK)) begin
         mask_d = writedata[WIDTH-1:0];
      end
      if (wr_en && (address == KEY_EDGECAP)) begin
         edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
      end
      // Set after clear: a press coinciding with a W1C is kept.
      edgecap_d = edgecap_d | press;
      irq_d     = |(edgecap_d & mask_d);
   end

   always_comb begin
      readdata_d = '0;
      if (rd_en) begin
         unique case (address)
            KEY_DATA:    readdata_d[WIDTH-1:0] = ~stable;
            KEY_IRQMASK: readdata_d[WIDTH-1:0] = mask_q;
            KEY_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:     readdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mask_q     <= '0;
         edgecap_q  <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         mask_q     <= mask_d;
         edgecap_q  <= edgecap_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_nios_system_key_ctrl.sv
module tb_nios_system_key_ctrl;
   import nios_system_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [2:0]  in_port;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   nios_system_key_ctrl #(
      .WIDTH        (3),
      .DEBOUNCE_CYC (4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] exp);
      tag_q.push_back(tag);
      exp_q.push_back(exp);
   endtask

   // Advance one clock, then compare readdata against the oldest queued expectation.
   task automatic tick_cmp();
      string       t;
      logic [31:0] e;
      tick();
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         chk(t, readdata, e);
      end
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] e, input string tag);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      push(tag, e);
      tick_cmp();
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = d;
      tick();
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = KEY_DATA;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 3'b111;

      // 1. reset state
      repeat (3) tick();
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      reset_n = 1'b1;
      rd(KEY_DATA,    32'h0, "rst_data");
      rd(KEY_EDGECAP, 32'h0, "rst_edgecap");
      rd(KEY_IRQMASK, 32'h0, "rst_irqmask");
      rd(KEY_RSVD,    32'h0, "rst_rsvd");

      // 2. key 0 press: EDGECAP sets on the 7th edge, visible in readdata on the 8th
      address    = KEY_EDGECAP;
      chipselect = 1'b1;
      write_n    = 1'b1;
      in_port[0] = 1'b0;
      for (int n = 1; n <= 8; n++) push($sformatf("press0_lat_%0d", n), (n == 8) ? 32'h1 : 32'h0);
      for (int n = 1; n <= 8; n++) begin
         tick_cmp();
         chk("press0_irq_masked", 32'(irq), 32'h0);
      end
      rd(KEY_DATA, 32'h1, "press0_data");

      // 3. 3-cycle glitch on key 1 must not be accepted
      address    = KEY_DATA;
      in_port[1] = 1'b0;
      for (int n = 0; n < 12; n++) push($sformatf("glitch1_data_%0d", n), 32'h1);
      for (int n = 0; n < 12; n++) begin
         if (n == 3) in_port[1] = 1'b1;
         tick_cmp();
         chk("glitch1_irq", 32'(irq), 32'h0);
      end
      rd(KEY_EDGECAP, 32'h1, "glitch1_edgecap");

      // 4. mask enables irq, W1C clears it
      wr(KEY_IRQMASK, 32'h5);
      chk("mask_irq_rise", 32'(irq), 32'h1);
      rd(KEY_IRQMASK, 32'h5, "mask_readback");
      wr(KEY_EDGECAP, 32'h1);
      chk("w1c_irq_fall", 32'(irq), 32'h0);
      rd(KEY_EDGECAP, 32'h0, "w1c_edgecap");

      // 5. W1C of bit 2 coincides with key 2's press pulse: the set wins
      chipselect = 1'b0;
      in_port[2] = 1'b0;
      repeat (6) tick();
      wr(KEY_EDGECAP, 32'h4);
      chk("collide_irq", 32'(irq), 32'h1);
      rd(KEY_EDGECAP, 32'h4, "collide_edgecap");
      chk("collide_irq_hold", 32'(irq), 32'h1);

      // releases never set EDGECAP bits
      address = KEY_EDGECAP;
      in_port = 3'b111;
      for (int n = 0; n < 10; n++) push($sformatf("release_edgecap_%0d", n), 32'h4);
      for (int n = 0; n < 10; n++) tick_cmp();
      rd(KEY_DATA, 32'h0, "release_data");
      wr(KEY_EDGECAP, 32'h4);
      chk("release_w1c_irq", 32'(irq), 32'h0);

      // 6. reset while key 0 is mid-debounce discards the partial count
      address    = KEY_DATA;
      chipselect = 1'b1;
      write_n    = 1'b1;
      in_port[0] = 1'b0;
      repeat (4) tick();
      reset_n = 1'b0;
      tick();
      chk("midrst_readdata", readdata, 32'h0);
      chk("midrst_irq", 32'(irq), 32'h0);
      reset_n = 1'b1;
      for (int n = 1; n <= 7; n++) push($sformatf("midrst_data_%0d", n), (n == 7) ? 32'h1 : 32'h0);
      for (int n = 1; n <= 7; n++) tick_cmp();
      rd(KEY_IRQMASK, 32'h0, "midrst_irqmask");
      rd(KEY_EDGECAP, 32'h1, "midrst_edgecap");
      chk("midrst_irq_masked", 32'(irq), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
